alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU (forward/add/and/or). Accepts operation requests (operands + ALUOP) over valid/ready, drives the registered operands onto the ALU, waits a fixed settle time for the ALU's combinational delay, captures the result, and returns it with the requester ID over a valid/ready response channel. Sits between the instruction-issue logic (two sources) and the ALU.

---
 rtl/alu_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/alu_arbiter.sv | 102 ++++++++++
 tb/tb_alu_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and the sequencer FSM state type.
package alu_pkg;

    localparam logic [2:0] ALUOP_FWD = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational grant from the two valids, with the
// last-granted pointer updated only when a grant is actually accepted.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (valid0 && valid1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = valid0;
            grant1 = valid1;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contended grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared 8-bit ALU: accepts one request, holds the
// operands for SETTLE_CYCLES, captures the result and returns it with the requester ID.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_data1,
    input  logic [7:0] req0_data2,
    input  logic [2:0] req0_select,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_data1,
    input  logic [7:0] req1_data2,
    input  logic [2:0] req1_select,
    output logic [7:0] alu_data1,
    output logic [7:0] alu_data2,
    output logic [2:0] alu_select,
    input  logic [7:0] alu_result,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [7:0] resp_result,
    output logic       resp_err
);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       op_id;
    logic       grant0;
    logic       grant1;
    logic       accept;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // Ready is gated by reset directly so it drops in the same cycle reset rises.
    assign req0_ready = (state == IDLE) && grant0 && !reset;
    assign req1_ready = (state == IDLE) && grant1 && !reset;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: all registers here are small flops, so each gets an explicit reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            settle_cnt  <= 4'd0;
            op_id       <= 1'b0;
            alu_data1   <= 8'h00;
            alu_data2   <= 8'h00;
            alu_select  <= ALUOP_FWD;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= 8'h00;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_data1  <= grant1 ? req1_data1  : req0_data1;
                        alu_data2  <= grant1 ? req1_data2  : req0_data2;
                        alu_select <= grant1 ? req1_select : req0_select;
                        op_id      <= grant1;
                        settle_cnt <= 4'(SETTLE_CYCLES);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Last settle cycle: ALU output has been stable long enough to sample.
                    if (settle_cnt == 4'd1) begin
                        resp_result <= alu_result;
                        resp_err    <= alu_select[2];
                        resp_id     <= op_id;
                        resp_valid  <= 1'b1;
                        state       <= RESPOND;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: timestamp-based reference model checked every cycle,
// a settle-aware ALU model, and directed scenarios with literal expectations.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_data1 = 8'h00, req0_data2 = 8'h00, req1_data1 = 8'h00, req1_data2 = 8'h00;
    logic [2:0] req0_select = 3'b000, req1_select = 3'b000;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_select;
    logic       resp_valid, resp_id, resp_err;
    logic       resp_ready = 1'b1;
    logic [7:0] resp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.SETTLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data1  (req0_data1),
        .req0_data2  (req0_data2),
        .req0_select (req0_select),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data1  (req1_data1),
        .req1_data2  (req1_data2),
        .req1_select (req1_select),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_select  (alu_select),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            ALUOP_FWD: return a;
            ALUOP_ADD: return a + b;
            ALUOP_AND: return a & b;
            ALUOP_OR:  return a | b;
            default:   return 8'h00;
        endcase
    endfunction

    // ALU with a settle delay: output is garbage until inputs have been stable S cycles.
    logic [18:0] alu_prev = '1;
    int          alu_age = 0;
    always @(negedge clk) begin
        if ({alu_data1, alu_data2, alu_select} != alu_prev) begin
            alu_prev = {alu_data1, alu_data2, alu_select};
            alu_age  = 1;
        end else begin
            alu_age++;
        end
    end
    assign alu_result = (alu_age >= S) ? alu_fn(alu_data1, alu_data2, alu_select) : 8'h5a;

    // Reference model: tracks the accepted operation by its accept cycle.
    int         cyc = 0;
    logic       m_busy = 1'b0;
    int         m_acc = 0;
    int         m_last = 1;
    logic [7:0] m_d1 = 8'h00, m_d2 = 8'h00;
    logic [2:0] m_sel = 3'b000;
    logic       m_rid = 1'b0, m_rerr = 1'b0, m_nid = 1'b0, m_nerr = 1'b0;
    logic [7:0] m_rres = 8'h00, m_nres = 8'h00;
    int         m_w;

    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 1) ? 0 : 1;
        if (v1) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_last = 1;
            m_d1 = 8'h00; m_d2 = 8'h00; m_sel = 3'b000;
            m_rid = 1'b0; m_rres = 8'h00; m_rerr = 1'b0;
        end else begin
            if (m_busy) begin
                if (cyc == m_acc + S) begin
                    m_rid = m_nid; m_rres = m_nres; m_rerr = m_nerr;
                end
                if (cyc >= m_acc + S + 1 && resp_ready) m_busy = 1'b0;
            end else if (req0_valid || req1_valid) begin
                m_w    = pick(req0_valid, req1_valid, m_last);
                m_last = m_w;
                m_busy = 1'b1;
                m_acc  = cyc;
                m_d1   = (m_w == 1) ? req1_data1  : req0_data1;
                m_d2   = (m_w == 1) ? req1_data2  : req0_data2;
                m_sel  = (m_w == 1) ? req1_select : req0_select;
                m_nid  = (m_w == 1);
                m_nres = alu_fn(m_d1, m_d2, m_sel);
                m_nerr = m_sel[2];
            end
            cyc++;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    int   c_w;
    logic c_e0, c_e1, c_ev;
    always @(negedge clk) begin
        if (reset) begin
            check("rst_req0_ready", 32'(req0_ready), 32'h0);
            check("rst_req1_ready", 32'(req1_ready), 32'h0);
            check("rst_alu_data1", 32'(alu_data1), 32'h0);
            check("rst_alu_data2", 32'(alu_data2), 32'h0);
            check("rst_alu_select", 32'(alu_select), 32'h0);
            check("rst_resp_valid", 32'(resp_valid), 32'h0);
            check("rst_resp_id", 32'(resp_id), 32'h0);
            check("rst_resp_result", 32'(resp_result), 32'h0);
            check("rst_resp_err", 32'(resp_err), 32'h0);
        end else begin
            c_w  = pick(req0_valid, req1_valid, m_last);
            c_e0 = !m_busy && (req0_valid || req1_valid) && (c_w == 0);
            c_e1 = !m_busy && (req0_valid || req1_valid) && (c_w == 1);
            c_ev = m_busy && (cyc >= m_acc + S + 1);
            check("req0_ready", 32'(req0_ready), 32'(c_e0));
            check("req1_ready", 32'(req1_ready), 32'(c_e1));
            check("alu_data1", 32'(alu_data1), 32'(m_d1));
            check("alu_data2", 32'(alu_data2), 32'(m_d2));
            check("alu_select", 32'(alu_select), 32'(m_sel));
            check("resp_valid", 32'(resp_valid), 32'(c_ev));
            check("resp_id", 32'(resp_id), 32'(m_rid));
            check("resp_result", 32'(resp_result), 32'(m_rres));
            check("resp_err", 32'(resp_err), 32'(m_rerr));
        end
    end

    // Handshake log used by the directed literal checks.
    int mon_cyc = 0;
    int acc_id[$], acc_cyc[$], rsp_id[$], rsp_res[$], rsp_err[$], rsp_cyc[$];
    always @(posedge clk) begin
        if (!reset) begin
            if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(mon_cyc); end
            if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(mon_cyc); end
            if (resp_valid && resp_ready) begin
                rsp_id.push_back(int'(resp_id));
                rsp_res.push_back(int'(resp_result));
                rsp_err.push_back(int'(resp_err));
                rsp_cyc.push_back(mon_cyc);
            end
        end
        mon_cyc++;
    end

    task automatic drive(input int r, input logic v, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [2:0] sel);
        if (r == 0) begin
            req0_valid = v; req0_data1 = d1; req0_data2 = d2; req0_select = sel;
        end else begin
            req1_valid = v; req1_data1 = d1; req1_data2 = d2; req1_select = sel;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_acc(input int n, input string name);
        int k = 0;
        while (acc_id.size() < n && k < 60) begin @(posedge clk); #1; k++; end
        check(name, 32'(acc_id.size() >= n), 32'h1);
    endtask

    task automatic wait_rsp(input int n, input string name);
        int k = 0;
        while (rsp_id.size() < n && k < 60) begin @(posedge clk); #1; k++; end
        check(name, 32'(rsp_id.size() >= n), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    int a, q, k;
    logic [7:0] exp_res[4] = '{8'h1a, 8'h02, 8'h1a, 8'h02};

    initial begin
        #1 reset = 1'b1;
        #2;
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        check("reset_alu_select", 32'(alu_select), 32'h0);
        step(3);
        reset = 1'b0;
        step(1);

        // Contention from reset: grants alternate starting with requester 0.
        a = acc_id.size(); q = rsp_id.size();
        drive(0, 1'b1, 8'h1a, 8'h12, ALUOP_OR);
        drive(1, 1'b1, 8'h12, 8'h02, ALUOP_AND);
        wait_acc(a + 4, "contend_accepts");
        drive(0, 1'b0, 8'h00, 8'h00, 3'b000);
        drive(1, 1'b0, 8'h00, 8'h00, 3'b000);
        wait_rsp(q + 4, "contend_resps");
        for (int i = 0; i < 4; i++) begin
            check("contend_grant", 32'(acc_id[a + i]), 32'(i % 2));
            check("contend_result", 32'(rsp_res[q + i]), 32'(exp_res[i]));
        end
        check("contend_spacing", 32'(acc_cyc[a + 1] - acc_cyc[a]), 32'd4);

        // Single request from requester 0: ADD 0x10 + 0x02.
        a = acc_id.size(); q = rsp_id.size();
        drive(0, 1'b1, 8'h10, 8'h02, ALUOP_ADD);
        wait_acc(a + 1, "add_accept");
        drive(0, 1'b0, 8'h00, 8'h00, 3'b000);
        wait_rsp(q + 1, "add_resp");
        check("add_id", 32'(rsp_id[q]), 32'd0);
        check("add_result", 32'(rsp_res[q]), 32'h12);
        check("add_err", 32'(rsp_err[q]), 32'd0);
        check("add_latency", 32'(rsp_cyc[q] - acc_cyc[a]), 32'd3);

        // Requester 1 ADD wraps to zero.
        a = acc_id.size(); q = rsp_id.size();
        drive(1, 1'b1, 8'hff, 8'h01, ALUOP_ADD);
        wait_acc(a + 1, "wrap_accept");
        drive(1, 1'b0, 8'h00, 8'h00, 3'b000);
        wait_rsp(q + 1, "wrap_resp");
        check("wrap_id", 32'(rsp_id[q]), 32'd1);
        check("wrap_result", 32'(rsp_res[q]), 32'h00);
        check("wrap_err", 32'(rsp_err[q]), 32'd0);

        // Undefined ALUOP is forwarded and flagged.
        a = acc_id.size(); q = rsp_id.size();
        drive(0, 1'b1, 8'h55, 8'h0f, 3'b101);
        wait_acc(a + 1, "undef_accept");
        drive(0, 1'b0, 8'h00, 8'h00, 3'b000);
        check("undef_alu_select", 32'(alu_select), 32'h5);
        check("undef_alu_data1", 32'(alu_data1), 32'h55);
        wait_rsp(q + 1, "undef_resp");
        check("undef_result", 32'(rsp_res[q]), 32'h00);
        check("undef_err", 32'(rsp_err[q]), 32'd1);

        // Back-pressure: response held while RESP_READY is low, new requests stall.
        resp_ready = 1'b0;
        a = acc_id.size(); q = rsp_id.size();
        drive(1, 1'b1, 8'h37, 8'h00, ALUOP_FWD);
        wait_acc(a + 1, "hold_accept");
        drive(1, 1'b0, 8'h00, 8'h00, 3'b000);
        drive(0, 1'b1, 8'h40, 8'h04, ALUOP_OR);
        k = 0;
        while (!resp_valid && k < 60) begin @(posedge clk); #1; k++; end
        check("hold_resp_valid_seen", 32'(resp_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", 32'(resp_result), 32'h37);
            check("hold_id", 32'(resp_id), 32'h1);
            check("hold_req0_ready", 32'(req0_ready), 32'h0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        wait_acc(a + 2, "release_accept");
        drive(0, 1'b0, 8'h00, 8'h00, 3'b000);
        check("release_grant", 32'(acc_id[a + 1]), 32'd0);
        check("release_next_cycle", 32'(acc_cyc[a + 1] - rsp_cyc[q]), 32'd1);
        wait_rsp(q + 2, "release_resp");
        check("hold_final_result", 32'(rsp_res[q]), 32'h37);
        check("release_result", 32'(rsp_res[q + 1]), 32'h44);

        // Reset during EXEC discards the operation and restores the pointer.
        a = acc_id.size(); q = rsp_id.size();
        drive(0, 1'b1, 8'h01, 8'h01, ALUOP_ADD);
        wait_acc(a + 1, "rst_exec_accept");
        drive(0, 1'b0, 8'h00, 8'h00, 3'b000);
        reset = 1'b1;
        #1;
        check("rst_exec_alu_data1", 32'(alu_data1), 32'h00);
        check("rst_exec_alu_select", 32'(alu_select), 32'h0);
        check("rst_exec_resp_result", 32'(resp_result), 32'h00);
        check("rst_exec_resp_valid", 32'(resp_valid), 32'h0);
        drive(0, 1'b1, 8'h0f, 8'hf0, ALUOP_OR);
        drive(1, 1'b1, 8'hff, 8'h3c, ALUOP_AND);
        #1;
        check("rst_exec_req0_ready", 32'(req0_ready), 32'h0);
        check("rst_exec_req1_ready", 32'(req1_ready), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_acc(a + 2, "post_rst_accept");
        drive(0, 1'b0, 8'h00, 8'h00, 3'b000);
        drive(1, 1'b0, 8'h00, 8'h00, 3'b000);
        check("post_rst_grant", 32'(acc_id[a + 1]), 32'd0);
        wait_rsp(q + 1, "post_rst_resp");
        step(4);
        check("post_rst_resp_count", 32'(rsp_id.size()), 32'(q + 1));
        check("post_rst_result", 32'(rsp_res[q]), 32'hff);
        check("post_rst_id", 32'(rsp_id[q]), 32'd0);

        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
